sram_controller: RTL and testbench

Downstream neighbour of the MEM-stage memory interface: takes the registered address, write value and 2-bit memory control, and runs one access against the external asynchronous 16-bit SRAM. It sequences chip-enable, output-enable and write-enable with programmable strobe width. It returns read data plus busy/done status to the pipeline. The SRAM data-bus tri-state buffer lives in the top level; this block only drives its enable.

---
 rtl/mem_pkg.sv | 23 ++
 rtl/sram_controller_if.sv | 31 +++
 rtl/sram_controller.sv | 123 ++++++++++++
 tb/tb_sram_controller.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_pkg.sv
// mem_pkg
// Shared definitions for the MEM stage, its interface and the SRAM
// controller: memory control encodings, the controller state enumeration
// and a helper that classifies a control code as a real access.
package mem_pkg;

   localparam logic [1:0] MEM_NONE  = 2'b00;
   localparam logic [1:0] MEM_READ  = 2'b01;
   localparam logic [1:0] MEM_WRITE = 2'b10;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_SETUP,
      ST_STROBE,
      ST_HOLD
   } sram_state_t;

   // Only read and write start an access; MEM_NONE and the reserved code do not.
   function automatic logic is_access(input logic [1:0] ctrl);
      return (ctrl == MEM_READ) || (ctrl == MEM_WRITE);
   endfunction

endpackage

// File: rtl/sram_controller_if.sv
// sram_controller_if
// Pipeline-side bundle between the MEM stage (master) and the SRAM
// controller (slave).
//   mem_req    request, sampled by the controller only while idle
//   mem_ctrl   2-bit memory control (none / read / write / reserved)
//   mem_addr   16-bit word address
//   mem_wdata  16-bit write value
//   mem_rdata  last read data, held until the next read completes
//   mem_busy   controller is running an access
//   mem_done   one-cycle pulse in the final cycle of every access
interface sram_controller_if;

   logic        mem_req;
   logic [1:0]  mem_ctrl;
   logic [15:0] mem_addr;
   logic [15:0] mem_wdata;
   logic [15:0] mem_rdata;
   logic        mem_busy;
   logic        mem_done;

   modport master (
      output mem_req, mem_ctrl, mem_addr, mem_wdata,
      input  mem_rdata, mem_busy, mem_done
   );

   modport slave (
      input  mem_req, mem_ctrl, mem_addr, mem_wdata,
      output mem_rdata, mem_busy, mem_done
   );

endinterface

// File: rtl/sram_controller.sv
// sram_controller
// Runs one access at a time against an external asynchronous 16-bit SRAM:
// SETUP (1 cycle), STROBE (WAIT_CYCLES cycles), HOLD (1 cycle), then IDLE.
// Ports:
//   clk, rst       clock and synchronous active-high reset
//   mem            pipeline side (sram_controller_if.slave)
//   sram_addr      {zeros, latched word address}
//   sram_data_out  latched write data toward the chip-level tri-state buffer
//   sram_data_oe   enable for that buffer, writes only, SETUP through HOLD
//   sram_data_in   SRAM data bus read-back
//   sram_ce_n, sram_oe_n, sram_we_n  registered active-low SRAM strobes
module sram_controller
   import mem_pkg::*;
#(
   parameter int WAIT_CYCLES = 2,
   parameter int SRAM_AW     = 18
) (
   input  logic               clk,
   input  logic               rst,
   sram_controller_if.slave   mem,
   output logic [SRAM_AW-1:0] sram_addr,
   output logic [15:0]        sram_data_out,
   output logic               sram_data_oe,
   input  logic [15:0]        sram_data_in,
   output logic               sram_ce_n,
   output logic               sram_oe_n,
   output logic               sram_we_n
);

   localparam logic [3:0] STROBE_LOAD = 4'(WAIT_CYCLES - 1);

   sram_state_t state, state_next;
   logic [3:0]  wait_cnt, wait_cnt_next;
   logic        accept, capture, write_next;
   logic        ce_n_next, oe_n_next, we_n_next, data_oe_next;
   logic [15:0] lat_addr, lat_wdata, rdata;
   logic        lat_write;

   // Next-state logic; strobe values are decoded from the next state so the
   // strobes can be registered and change cleanly on the clock edge.
   always_comb begin
      state_next    = state;
      wait_cnt_next = wait_cnt;
      accept        = 1'b0;
      capture       = 1'b0;
      case (state)
         ST_IDLE: begin
            if (mem.mem_req && is_access(mem.mem_ctrl)) begin
               accept     = 1'b1;
               state_next = ST_SETUP;
            end
         end
         ST_SETUP: begin
            state_next    = ST_STROBE;
            wait_cnt_next = STROBE_LOAD;
         end
         ST_STROBE: begin
            if (wait_cnt == 4'd0) begin
               state_next = ST_HOLD;
               capture    = !lat_write;
            end else begin
               wait_cnt_next = wait_cnt - 4'd1;
            end
         end
         ST_HOLD: begin
            state_next = ST_IDLE;
         end
         default: begin
            state_next = ST_IDLE;
         end
      endcase

      // On the accepting edge the latched direction is not yet updated.
      write_next   = accept ? (mem.mem_ctrl == MEM_WRITE) : lat_write;
      ce_n_next    = (state_next == ST_IDLE);
      oe_n_next    = !((state_next == ST_STROBE) && !write_next);
      we_n_next    = !((state_next == ST_STROBE) && write_next);
      data_oe_next = (state_next != ST_IDLE) && write_next;
   end

   // State, latched request, read data and registered strobes.
   always_ff @(posedge clk) begin
      if (rst) begin
         state        <= ST_IDLE;
         wait_cnt     <= 4'd0;
         lat_addr     <= 16'd0;
         lat_wdata    <= 16'd0;
         lat_write    <= 1'b0;
         rdata        <= 16'd0;
         sram_ce_n    <= 1'b1;
         sram_oe_n    <= 1'b1;
         sram_we_n    <= 1'b1;
         sram_data_oe <= 1'b0;
      end else begin
         state        <= state_next;
         wait_cnt     <= wait_cnt_next;
         sram_ce_n    <= ce_n_next;
         sram_oe_n    <= oe_n_next;
         sram_we_n    <= we_n_next;
         sram_data_oe <= data_oe_next;
         if (accept) begin
            lat_addr  <= mem.mem_addr;
            lat_wdata <= mem.mem_wdata;
            lat_write <= (mem.mem_ctrl == MEM_WRITE);
         end else if (state == ST_HOLD) begin
            // Address and data return to zero in IDLE, one cycle after
            // we_n has already risen in HOLD.
            lat_addr  <= 16'd0;
            lat_wdata <= 16'd0;
         end
         if (capture) begin
            rdata <= sram_data_in;
         end
      end
   end

   assign mem.mem_rdata  = rdata;
   assign mem.mem_busy   = (state != ST_IDLE);
   assign mem.mem_done   = (state == ST_HOLD);
   assign sram_addr      = SRAM_AW'(lat_addr);
   assign sram_data_out  = lat_wdata;

endmodule

// File: tb/tb_sram_controller.sv
// tb_sram_controller
// Directed bench for sram_controller: a cycle-by-cycle vector table on a
// WAIT_CYCLES=2 instance backed by a small SRAM model, plus hand-written
// sequences for WAIT_CYCLES=1 and 4 reads and a reset during a write strobe.
module tb_sram_controller;
   import mem_pkg::*;

   // {busy, done, ce_n, oe_n, we_n, data_oe}
   localparam logic [5:0] C_IDLE     = 6'b001110;
   localparam logic [5:0] C_SETUP_W  = 6'b100111;
   localparam logic [5:0] C_STROBE_W = 6'b100101;
   localparam logic [5:0] C_HOLD_W   = 6'b110111;
   localparam logic [5:0] C_SETUP_R  = 6'b100110;
   localparam logic [5:0] C_STROBE_R = 6'b100010;
   localparam logic [5:0] C_HOLD_R   = 6'b110110;

   typedef struct {
      logic        req;
      logic [1:0]  ctrl;
      logic [15:0] addr;
      logic [15:0] wdata;
      logic [5:0]  exp_ctl;
      logic [15:0] exp_rdata;
      logic [17:0] exp_saddr;
      logic [15:0] exp_dout;
   } vec_t;

   logic clk;
   logic rst;
   int   checks;
   int   failures;

   sram_controller_if mif ();
   sram_controller_if mif1 ();
   sram_controller_if mif4 ();

   logic [17:0] sram_addr, sram_addr1, sram_addr4;
   logic [15:0] sram_data_out, sram_data_out1, sram_data_out4;
   logic [15:0] sram_data_in, sram_data_in1, sram_data_in4;
   logic        sram_data_oe, sram_data_oe1, sram_data_oe4;
   logic        sram_ce_n, sram_oe_n, sram_we_n;
   logic        sram_ce_n1, sram_oe_n1, sram_we_n1;
   logic        sram_ce_n4, sram_oe_n4, sram_we_n4;

   sram_controller #(.WAIT_CYCLES(2), .SRAM_AW(18)) u_dut (
      .clk(clk), .rst(rst), .mem(mif.slave),
      .sram_addr(sram_addr), .sram_data_out(sram_data_out),
      .sram_data_oe(sram_data_oe), .sram_data_in(sram_data_in),
      .sram_ce_n(sram_ce_n), .sram_oe_n(sram_oe_n), .sram_we_n(sram_we_n)
   );

   sram_controller #(.WAIT_CYCLES(1), .SRAM_AW(18)) u_dut1 (
      .clk(clk), .rst(rst), .mem(mif1.slave),
      .sram_addr(sram_addr1), .sram_data_out(sram_data_out1),
      .sram_data_oe(sram_data_oe1), .sram_data_in(sram_data_in1),
      .sram_ce_n(sram_ce_n1), .sram_oe_n(sram_oe_n1), .sram_we_n(sram_we_n1)
   );

   sram_controller #(.WAIT_CYCLES(4), .SRAM_AW(18)) u_dut4 (
      .clk(clk), .rst(rst), .mem(mif4.slave),
      .sram_addr(sram_addr4), .sram_data_out(sram_data_out4),
      .sram_data_oe(sram_data_oe4), .sram_data_in(sram_data_in4),
      .sram_ce_n(sram_ce_n4), .sram_oe_n(sram_oe_n4), .sram_we_n(sram_we_n4)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // SRAM model for the main instance; reset preloads two read locations.
   logic [15:0] sram_mem [0:65535];
   always @(posedge clk) begin
      if (rst) begin
         sram_mem[16'h0010] <= 16'h1234;
         sram_mem[16'h0011] <= 16'h5678;
      end else if (!sram_ce_n && !sram_we_n && sram_data_oe) begin
         sram_mem[sram_addr[15:0]] <= sram_data_out;
      end
   end
   assign sram_data_in  = (!sram_ce_n && !sram_oe_n) ? sram_mem[sram_addr[15:0]] : 16'hDEAD;
   assign sram_data_in1 = (!sram_ce_n1 && !sram_oe_n1) ? 16'h5A5A : 16'h0000;
   assign sram_data_in4 = (!sram_ce_n4 && !sram_oe_n4) ? 16'h5A5A : 16'h0000;

   task automatic apply_stimulus(input logic req, input logic [1:0] ctrl,
                                 input logic [15:0] addr, input logic [15:0] wdata);
      mif.mem_req   = req;
      mif.mem_ctrl  = ctrl;
      mif.mem_addr  = addr;
      mif.mem_wdata = wdata;
   endtask

   task automatic check_output(input string name, input logic [5:0] exp_ctl,
                               input logic [15:0] exp_rdata, input logic [17:0] exp_saddr,
                               input logic [15:0] exp_dout);
      logic [5:0] ctl;
      ctl = {mif.mem_busy, mif.mem_done, sram_ce_n, sram_oe_n, sram_we_n, sram_data_oe};
      checks++;
      if (ctl !== exp_ctl || mif.mem_rdata !== exp_rdata ||
          sram_addr !== exp_saddr || sram_data_out !== exp_dout) begin
         failures++;
         $display("[TB] FAIL %s: got ctl=%b rdata=%h addr=%h dout=%h, expected ctl=%b rdata=%h addr=%h dout=%h",
                  name, ctl, mif.mem_rdata, sram_addr, sram_data_out,
                  exp_ctl, exp_rdata, exp_saddr, exp_dout);
      end
   endtask

   task automatic check_int(input string name, input int got, input int exp);
      checks++;
      if (got != exp) begin
         failures++;
         $display("[TB] FAIL %s: got %0d, expected %0d", name, got, exp);
      end
   endtask

   // Issue one read on an auxiliary instance (which = 1 or 4) and report the
   // cycle of the done pulse relative to the request cycle, oe_n low width,
   // number of done pulses and final read data.
   task automatic run_aux_read(input int which, output int done_at, output int oe_low,
                               output int done_cnt, output logic [15:0] rdata);
      done_at  = 0;
      oe_low   = 0;
      done_cnt = 0;
      if (which == 1) begin
         mif1.mem_req = 1'b1; mif1.mem_ctrl = MEM_READ; mif1.mem_addr = 16'h0042;
      end else begin
         mif4.mem_req = 1'b1; mif4.mem_ctrl = MEM_READ; mif4.mem_addr = 16'h0042;
      end
      @(posedge clk);
      @(negedge clk);
      mif1.mem_req = 1'b0;
      mif4.mem_req = 1'b0;
      for (int n = 1; n <= 20; n++) begin
         if ((which == 1) ? !sram_oe_n1 : !sram_oe_n4) oe_low++;
         if ((which == 1) ? mif1.mem_done : mif4.mem_done) begin
            done_cnt++;
            if (done_at == 0) done_at = n;
         end
         @(posedge clk);
         @(negedge clk);
      end
      rdata = (which == 1) ? mif1.mem_rdata : mif4.mem_rdata;
   endtask

   function automatic vec_t mk(input logic req, input logic [1:0] ctrl,
                               input logic [15:0] addr, input logic [15:0] wdata,
                               input logic [5:0] exp_ctl, input logic [15:0] exp_rdata,
                               input logic [17:0] exp_saddr, input logic [15:0] exp_dout);
      vec_t v;
      v.req = req; v.ctrl = ctrl; v.addr = addr; v.wdata = wdata;
      v.exp_ctl = exp_ctl; v.exp_rdata = exp_rdata;
      v.exp_saddr = exp_saddr; v.exp_dout = exp_dout;
      return v;
   endfunction

   initial begin
      vec_t vecs[22];
      int   done_at, oe_low, done_cnt, saw_done;
      logic [15:0] aux_rdata;

      checks   = 0;
      failures = 0;

      // Row i is driven during cycle i; the expectation is the cycle after.
      // Write 0xBEEF to 0x0123, then read it back.
      vecs[0]  = mk(1'b1, 2'b10, 16'h0123, 16'hBEEF, C_SETUP_W,  16'h0000, 18'h00123, 16'hBEEF);
      vecs[1]  = mk(1'b0, 2'b00, 16'hFFFF, 16'h0000, C_STROBE_W, 16'h0000, 18'h00123, 16'hBEEF);
      vecs[2]  = mk(1'b1, 2'b01, 16'hFFFF, 16'h1111, C_STROBE_W, 16'h0000, 18'h00123, 16'hBEEF);
      vecs[3]  = mk(1'b0, 2'b00, 16'h0000, 16'h0000, C_HOLD_W,   16'h0000, 18'h00123, 16'hBEEF);
      vecs[4]  = mk(1'b1, 2'b01, 16'h0123, 16'h0000, C_IDLE,     16'h0000, 18'h00000, 16'h0000);
      vecs[5]  = mk(1'b1, 2'b01, 16'h0123, 16'h0000, C_SETUP_R,  16'h0000, 18'h00123, 16'h0000);
      vecs[6]  = mk(1'b0, 2'b00, 16'h0000, 16'h0000, C_STROBE_R, 16'h0000, 18'h00123, 16'h0000);
      vecs[7]  = mk(1'b0, 2'b00, 16'h0000, 16'h0000, C_STROBE_R, 16'h0000, 18'h00123, 16'h0000);
      vecs[8]  = mk(1'b0, 2'b00, 16'h0000, 16'h0000, C_HOLD_R,   16'hBEEF, 18'h00123, 16'h0000);
      vecs[9]  = mk(1'b0, 2'b00, 16'h0000, 16'h0000, C_IDLE,     16'hBEEF, 18'h00000, 16'h0000);
      // Reserved and no-op control codes are ignored.
      vecs[10] = mk(1'b1, 2'b11, 16'h0200, 16'h7777, C_IDLE,     16'hBEEF, 18'h00000, 16'h0000);
      vecs[11] = mk(1'b1, 2'b00, 16'h0201, 16'h7777, C_IDLE,     16'hBEEF, 18'h00000, 16'h0000);
      // Held read request, address stepping 0x0010 -> 0x0011.
      vecs[12] = mk(1'b1, 2'b01, 16'h0010, 16'h0000, C_SETUP_R,  16'hBEEF, 18'h00010, 16'h0000);
      vecs[13] = mk(1'b1, 2'b01, 16'h0011, 16'h2222, C_STROBE_R, 16'hBEEF, 18'h00010, 16'h0000);
      vecs[14] = mk(1'b1, 2'b01, 16'h0011, 16'h2222, C_STROBE_R, 16'hBEEF, 18'h00010, 16'h0000);
      vecs[15] = mk(1'b1, 2'b01, 16'h0011, 16'h2222, C_HOLD_R,   16'h1234, 18'h00010, 16'h0000);
      vecs[16] = mk(1'b1, 2'b01, 16'h0011, 16'h0000, C_IDLE,     16'h1234, 18'h00000, 16'h0000);
      vecs[17] = mk(1'b1, 2'b01, 16'h0011, 16'h0000, C_SETUP_R,  16'h1234, 18'h00011, 16'h0000);
      vecs[18] = mk(1'b1, 2'b01, 16'h0099, 16'h3333, C_STROBE_R, 16'h1234, 18'h00011, 16'h0000);
      vecs[19] = mk(1'b0, 2'b00, 16'h0099, 16'h3333, C_STROBE_R, 16'h1234, 18'h00011, 16'h0000);
      vecs[20] = mk(1'b0, 2'b00, 16'h0000, 16'h0000, C_HOLD_R,   16'h5678, 18'h00011, 16'h0000);
      vecs[21] = mk(1'b0, 2'b00, 16'h0000, 16'h0000, C_IDLE,     16'h5678, 18'h00000, 16'h0000);

      rst = 1'b1;
      apply_stimulus(1'b0, MEM_NONE, 16'h0000, 16'h0000);
      mif1.mem_req = 1'b0; mif1.mem_ctrl = MEM_NONE; mif1.mem_addr = 16'h0; mif1.mem_wdata = 16'h0;
      mif4.mem_req = 1'b0; mif4.mem_ctrl = MEM_NONE; mif4.mem_addr = 16'h0; mif4.mem_wdata = 16'h0;
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;
      @(posedge clk);
      @(negedge clk);
      check_output("reset_idle", C_IDLE, 16'h0000, 18'h00000, 16'h0000);

      for (int i = 0; i < 22; i++) begin
         apply_stimulus(vecs[i].req, vecs[i].ctrl, vecs[i].addr, vecs[i].wdata);
         @(posedge clk);
         @(negedge clk);
         check_output($sformatf("vec%0d", i), vecs[i].exp_ctl, vecs[i].exp_rdata,
                      vecs[i].exp_saddr, vecs[i].exp_dout);
      end

      // WAIT_CYCLES=1: done at k+3, oe_n low one cycle.
      run_aux_read(1, done_at, oe_low, done_cnt, aux_rdata);
      check_int("w1_done_cycle", done_at, 3);
      check_int("w1_oe_width", oe_low, 1);
      check_int("w1_done_count", done_cnt, 1);
      check_int("w1_rdata", int'(aux_rdata), 32'h5A5A);

      // WAIT_CYCLES=4: done at k+6, oe_n low four cycles.
      run_aux_read(4, done_at, oe_low, done_cnt, aux_rdata);
      check_int("w4_done_cycle", done_at, 6);
      check_int("w4_oe_width", oe_low, 4);
      check_int("w4_done_count", done_cnt, 1);
      check_int("w4_rdata", int'(aux_rdata), 32'h5A5A);

      // Reset in the second strobe cycle of a write.
      apply_stimulus(1'b1, MEM_WRITE, 16'h0300, 16'hCAFE);
      @(posedge clk);
      @(negedge clk);
      apply_stimulus(1'b0, MEM_NONE, 16'h0000, 16'h0000);
      @(posedge clk);
      @(posedge clk);
      @(negedge clk);
      check_output("rst_mid_strobe2", C_STROBE_W, 16'h5678, 18'h00300, 16'hCAFE);
      rst = 1'b1;
      @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      check_output("rst_mid_after", C_IDLE, 16'h0000, 18'h00000, 16'h0000);
      saw_done = 0;
      for (int n = 0; n < 6; n++) begin
         @(posedge clk);
         @(negedge clk);
         if (mif.mem_done) saw_done++;
      end
      check_int("rst_mid_no_done", saw_done, 0);
      check_output("rst_mid_idle", C_IDLE, 16'h0000, 18'h00000, 16'h0000);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
